sad_pe_array: RTL

Processing-element array feeding the 16x16 SAD reduction tree in inter prediction. Captures one current macroblock (16 rows of 16 pixels), then streams candidate reference blocks row by row and builds the per-pixel absolute-difference array `sad[x][y]` for each candidate. It presents the array to the SAD adder tree with a valid/ready handshake. It tags each result with its candidate index and signals the end of a search.

---
 rtl/sad_pe_array.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sad_pe_array.sv
// Processing-element array: stores one current macroblock, then builds per-pixel |cur-ref|
// arrays for each streamed reference candidate. Define SAD_PE_DOUBLE_BUF_EN for a separate output buffer.
module sad_pe_array #(
  parameter int unsigned PIX_WIDTH = 8,
  parameter int unsigned PEX       = 16,
  parameter int unsigned PEY       = 16,
  parameter int unsigned NUM_CAND  = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic [PEX*PIX_WIDTH-1:0]                   cur_row,
  input  logic                                       cur_valid,
  output logic                                       cur_ready,
  input  logic [PEX*PIX_WIDTH-1:0]                   ref_row,
  input  logic                                       ref_valid,
  output logic                                       ref_ready,
  output logic [0:PEX-1][0:PEY-1][PIX_WIDTH-1:0]     sad,
  output logic                                       sad_valid,
  input  logic                                       sad_ready,
  output logic [((NUM_CAND > 1) ? $clog2(NUM_CAND) : 1)-1:0] cand_idx,
  output logic                                       done,
  output logic                                       busy
);

  localparam int unsigned RW  = (PEY > 1) ? $clog2(PEY) : 1;
  localparam int unsigned CIW = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
  localparam int unsigned CCW = $clog2(NUM_CAND + 1);

  typedef enum logic [1:0] {IDLE, LOAD_CUR, SEARCH, HOLD} state_t;

  state_t                                   state;
  logic [RW-1:0]                            row_cnt;
  logic [CCW-1:0]                           cand_cnt;
  logic [PEX*PIX_WIDTH-1:0]                 cur_mem [PEY];
  logic [PEX*PIX_WIDTH-1:0]                 cur_line;
  logic [0:PEX-1][PIX_WIDTH-1:0]            diff;
  logic [0:PEX-1][0:PEY-1][PIX_WIDTH-1:0]   work;
  logic                                     last_row;
  logic                                     all_recv;
  logic                                     ref_accept;

  assign last_row   = (row_cnt == RW'(PEY - 1));
  assign all_recv   = (cand_cnt == CCW'(NUM_CAND));
  assign busy       = (state != IDLE);
  assign cur_ready  = (state == LOAD_CUR);
  assign ref_accept = ref_valid && ref_ready;
  assign cur_line   = cur_mem[row_cnt];

`ifdef SAD_PE_DOUBLE_BUF_EN
  // Stall only the row that would complete a candidate while the previous one is still unconsumed.
  assign ref_ready = (state == SEARCH) && !all_recv && !(last_row && sad_valid && !sad_ready);
`else
  assign ref_ready = (state == SEARCH);
  assign sad       = work;
`endif

  // Current macroblock storage; kept for the whole search, rewritten only by the next load.
  always_ff @(posedge clk) begin
    if (cur_valid && cur_ready) begin
      cur_mem[row_cnt] <= cur_row;
    end
  end

  // Unsigned compare-and-subtract; the magnitude always fits in PIX_WIDTH bits.
  always_comb begin
    diff = '0;
    for (int x = 0; x < int'(PEX); x++) begin
      if (cur_line[x*PIX_WIDTH +: PIX_WIDTH] >= ref_row[x*PIX_WIDTH +: PIX_WIDTH]) begin
        diff[x] = cur_line[x*PIX_WIDTH +: PIX_WIDTH] - ref_row[x*PIX_WIDTH +: PIX_WIDTH];
      end else begin
        diff[x] = ref_row[x*PIX_WIDTH +: PIX_WIDTH] - cur_line[x*PIX_WIDTH +: PIX_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      row_cnt   <= '0;
      cand_cnt  <= '0;
      cand_idx  <= '0;
      sad_valid <= 1'b0;
      done      <= 1'b0;
      work      <= '0;
`ifdef SAD_PE_DOUBLE_BUF_EN
      sad       <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          row_cnt  <= '0;
          cand_cnt <= '0;
          if (start) begin
            state <= LOAD_CUR;
          end
        end

        LOAD_CUR: begin
          if (cur_valid && cur_ready) begin
            if (last_row) begin
              row_cnt <= '0;
              state   <= SEARCH;
            end else begin
              row_cnt <= row_cnt + RW'(1);
            end
          end
        end

        SEARCH: begin
`ifdef SAD_PE_DOUBLE_BUF_EN
          // Output handshake runs alongside row accumulation; a same-edge completion re-asserts valid below.
          if (sad_valid && sad_ready) begin
            sad_valid <= 1'b0;
            if (all_recv) begin
              done  <= 1'b1;
              state <= IDLE;
            end
          end
`endif
          if (ref_accept) begin
            for (int x = 0; x < int'(PEX); x++) begin
              work[x][row_cnt] <= diff[x];
            end
            if (last_row) begin
              row_cnt   <= '0;
              cand_cnt  <= cand_cnt + CCW'(1);
              cand_idx  <= CIW'(cand_cnt);
              sad_valid <= 1'b1;
`ifdef SAD_PE_DOUBLE_BUF_EN
              for (int x = 0; x < int'(PEX); x++) begin
                for (int y = 0; y < int'(PEY); y++) begin
                  sad[x][y] <= (RW'(y) == row_cnt) ? diff[x] : work[x][y];
                end
              end
`else
              state     <= HOLD;
`endif
            end else begin
              row_cnt <= row_cnt + RW'(1);
            end
          end
        end

        HOLD: begin
          if (sad_ready) begin
            sad_valid <= 1'b0;
            if (all_recv) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              state <= SEARCH;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
